// File: rtl/seq_magnitude_comparator_if.sv
// seq_magnitude_comparator_if
//   Bundles the request/result signals of the sequential magnitude comparator.
//   master: requester (drives start, is_signed, a, b; observes results)
//   slave : comparator (observes the request; drives busy, done and the flags)
//   Signals:
//     start      request a compare (accepted only while busy=0)
//     is_signed  1 = two's-complement compare, 0 = unsigned
//     a, b       WIDTH-bit operands, sampled on the accepting edge
//     busy       compare in progress
//     done       one-cycle pulse, flags valid
//     a_lt_b / a_gt_b / a_eq_b  result flags (exactly one set after done)
interface seq_magnitude_comparator_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             a_lt_b;
    logic             a_gt_b;
    logic             a_eq_b;

    modport master (
        output start, is_signed, a, b,
        input  busy, done, a_lt_b, a_gt_b, a_eq_b
    );

    modport slave (
        input  start, is_signed, a, b,
        output busy, done, a_lt_b, a_gt_b, a_eq_b
    );
endinterface

// File: rtl/seq_magnitude_comparator.sv
// seq_magnitude_comparator
//   Multi-cycle magnitude comparator. Operands are compared MSB-first, DIGIT
//   bits per clock, under a start/busy/done handshake. Signed mode flips the
//   sign bit of both latched operands (offset binary) so a single unsigned
//   digit walk serves both modes.
//
//   Build option: SEQ_CMP_EARLY_EXIT_EN
//     defined   - finish on the first differing digit (data-dependent latency)
//     undefined - always walk all N digits, constant latency of N cycles;
//                 only the most-significant difference decides the result
//
//   Ports:
//     clk  clock, rising edge
//     rst  asynchronous active-high reset (aborts any compare, no done pulse)
//     bus  seq_magnitude_comparator_if.slave request/result bundle
module seq_magnitude_comparator #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    seq_magnitude_comparator_if.slave     bus
);
    localparam int N    = WIDTH / DIGIT;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDXW-1:0] IDX_TOP = IDXW'(N - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_CMP  = 1'b1;

    generate
        if ((WIDTH % DIGIT) != 0 || WIDTH < 2) begin : g_bad_params
            $error("seq_magnitude_comparator: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

    logic [0:0]                  state;
    logic [IDXW-1:0]             idx;
    logic [N-1:0][DIGIT-1:0]     a_q;
    logic [N-1:0][DIGIT-1:0]     b_q;
    logic                        busy_q;
    logic                        done_q;
    logic                        lt_q;
    logic                        gt_q;
    logic                        eq_q;

    // Current digit pair under comparison.
    logic [DIGIT-1:0] a_dig;
    logic [DIGIT-1:0] b_dig;
    logic             dig_ne;
    logic             dig_gt;

    assign a_dig  = a_q[idx];
    assign b_dig  = b_q[idx];
    assign dig_ne = (a_dig != b_dig);
    assign dig_gt = (a_dig >  b_dig);

    // Sign-bit flip turns two's complement into offset binary.
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    assign a_in = {bus.a[WIDTH-1] ^ bus.is_signed, bus.a[WIDTH-2:0]};
    assign b_in = {bus.b[WIDTH-1] ^ bus.is_signed, bus.b[WIDTH-2:0]};

`ifndef SEQ_CMP_EARLY_EXIT_EN
    // First (most-significant) difference seen during the full walk.
    logic seen_q;
    logic seen_gt_q;
    logic fin_ne;
    logic fin_gt;
    assign fin_ne = seen_q | dig_ne;
    assign fin_gt = seen_q ? seen_gt_q : dig_gt;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            idx       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            lt_q      <= 1'b0;
            gt_q      <= 1'b0;
            eq_q      <= 1'b0;
`ifndef SEQ_CMP_EARLY_EXIT_EN
            seen_q    <= 1'b0;
            seen_gt_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        a_q    <= a_in;
                        b_q    <= b_in;
                        lt_q   <= 1'b0;
                        gt_q   <= 1'b0;
                        eq_q   <= 1'b0;
                        busy_q <= 1'b1;
                        idx    <= IDX_TOP;
                        state  <= S_CMP;
`ifndef SEQ_CMP_EARLY_EXIT_EN
                        seen_q    <= 1'b0;
                        seen_gt_q <= 1'b0;
`endif
                    end
                end
                S_CMP: begin
`ifdef SEQ_CMP_EARLY_EXIT_EN
                    if (dig_ne) begin
                        gt_q   <= dig_gt;
                        lt_q   <= ~dig_gt;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= S_IDLE;
                    end else if (idx == '0) begin
                        eq_q   <= 1'b1;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= S_IDLE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
`else
                    if (!seen_q && dig_ne) begin
                        seen_q    <= 1'b1;
                        seen_gt_q <= dig_gt;
                    end
                    if (idx == '0) begin
                        gt_q   <= fin_ne & fin_gt;
                        lt_q   <= fin_ne & ~fin_gt;
                        eq_q   <= ~fin_ne;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= S_IDLE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.a_lt_b = lt_q;
    assign bus.a_gt_b = gt_q;
    assign bus.a_eq_b = eq_q;
endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// tb_seq_magnitude_comparator
//   Directed bench for seq_magnitude_comparator at WIDTH=8, DIGIT=2 (N=4).
//   Expected latencies follow SEQ_CMP_EARLY_EXIT_EN when it is defined.
module tb_seq_magnitude_comparator;
    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;
    int   lat;

    seq_magnitude_comparator_if #(.WIDTH(8)) bus ();

    seq_magnitude_comparator #(.WIDTH(8), .DIGIT(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected cycles from accepting edge to done for d equal leading digits.
    function automatic int exp_lat(input int d);
`ifdef SEQ_CMP_EARLY_EXIT_EN
        return d + 1;
`else
        return 4 + (d - d);
`endif
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int flags();
        return {29'd0, bus.a_lt_b, bus.a_gt_b, bus.a_eq_b};
    endfunction

    // Drive a request so that the next rising edge is the accepting edge k;
    // returns #1 after edge k with start released.
    task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic s);
        bus.start     = 1'b1;
        bus.a         = a;
        bus.b         = b;
        bus.is_signed = s;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Counts edges after k until done is seen; -1 if the bound expires.
    task automatic wait_done(output int l);
        l = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                l = i;
                break;
            end
        end
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.is_signed = 1'b0;
        bus.a = '0;
        bus.b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_flags", flags(), 0);
        chk("reset_busy_done", {bus.busy, bus.done}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 1. Reset mid-compare: outputs drop immediately, no done pulse.
        start_op(8'h7A, 8'h7B, 1'b0);
        chk("mid_busy", bus.busy, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_async_busy", bus.busy, 0);
        chk("rst_async_flags", {bus.done, bus.a_lt_b, bus.a_gt_b, bus.a_eq_b}, 0);
        repeat (4) begin
            @(posedge clk);
            #1;
            chk("rst_no_done", bus.done, 0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        start_op(8'h7A, 8'h7B, 1'b0);
        wait_done(lat);
        chk("post_rst_lat", lat, exp_lat(3));
        chk("post_rst_flags", flags(), 3'b100);

        // 2. Unsigned early exit at the MS digit.
        @(negedge clk);
        start_op(8'hF0, 8'h30, 1'b0);
        chk("u_busy_k", bus.busy, 1);
        wait_done(lat);
        chk("u_lat", lat, exp_lat(0));
        chk("u_flags", flags(), 3'b010);
        chk("u_busy_done", bus.busy, 0);
        @(posedge clk);
        #1;
        chk("u_done_pulse", bus.done, 0);
        chk("u_flags_hold", flags(), 3'b010);

        // 3. Signed: -16 < 48; boundary -128 vs 127 both modes.
        @(negedge clk);
        start_op(8'hF0, 8'h30, 1'b1);
        wait_done(lat);
        chk("s_lat", lat, exp_lat(0));
        chk("s_flags", flags(), 3'b100);
        @(negedge clk);
        start_op(8'h80, 8'h7F, 1'b1);
        wait_done(lat);
        chk("s_min_max", flags(), 3'b100);
        @(negedge clk);
        start_op(8'h80, 8'h7F, 1'b0);
        wait_done(lat);
        chk("u_min_max", flags(), 3'b010);

        // 4. Equal and last-digit difference take the full N cycles.
        @(negedge clk);
        start_op(8'h99, 8'h99, 1'b0);
        wait_done(lat);
        chk("eq_lat", lat, 4);
        chk("eq_flags", flags(), 3'b001);
        @(negedge clk);
        start_op(8'h7A, 8'h7B, 1'b0);
        wait_done(lat);
        chk("lsd_lat", lat, 4);
        chk("lsd_flags", flags(), 3'b100);

        // 5a. start while busy is ignored.
        @(negedge clk);
        start_op(8'h99, 8'h98, 1'b0);
        bus.start = 1'b1;
        bus.a = 8'h00;
        bus.b = 8'hFF;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("ign_busy", bus.busy, 1);
        for (int i = 2; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = i;
                break;
            end
            lat = -1;
        end
        chk("ign_lat", lat, 4);
        chk("ign_flags", flags(), 3'b010);

        // 5b. start in the done cycle is accepted back-to-back.
        start_op(8'h09, 8'h09, 1'b0);
        chk("b2b_busy", bus.busy, 1);
        chk("b2b_clear", flags(), 0);
        wait_done(lat);
        chk("b2b_lat", lat, 4);
        chk("b2b_flags", flags(), 3'b001);

        // 6. Operand changes after the accepting edge have no effect.
        @(negedge clk);
        start_op(8'h3C, 8'h3D, 1'b0);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            bus.a = 8'($urandom);
            bus.b = 8'($urandom);
            bus.is_signed = 1'($urandom);
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = i;
                break;
            end
        end
        chk("stab_lat", lat, 4);
        chk("stab_flags", flags(), 3'b100);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
